pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_md_busy_counter.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        MEMST_IDLE = 1'b0,
        MEMST_WAIT = 1'b1
    } mem_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic reg_hit(input logic use_f, input logic [4:0] src, input logic [4:0] dst);
        return use_f && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_counter.sv
// rtl/pipeline_hazard_ctrl_md_busy_counter.sv - mult/div occupancy counter for the HI/LO unit
module md_busy_counter #(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    output logic [CNT_W-1:0] count,
    output logic             md_busy
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A new start reloads the counter even if the unit is still busy.
    always_comb begin
        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = CNT_W'(MD_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_use_hilo,
    input  logic       id_jump,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_write_addr,
    input  logic       ex_branch_taken,
    input  logic       md_start,
    input  logic       mem_MemRead,
    input  logic       mem_MemWrite,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_write,
    output logic       id_ex_flush,
    output logic       ex_mem_write,
    output logic       mem_wb_flush,
    output logic       md_busy
);

    mem_state_e       state_q;
    mem_state_e       state_d;
    logic             access;
    logic             freeze;
    logic             ld_stall;
    logic             md_stall;
    logic             md_busy_raw;
    logic [CNT_W-1:0] md_count;

    assign access = mem_MemRead | mem_MemWrite;

    md_busy_counter #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_cnt (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start & ~freeze),
        .count    (md_count),
        .md_busy  (md_busy_raw)
    );

    assign md_busy  = reset & md_busy_raw;
    assign ld_stall = ex_MemRead && (ex_write_addr != REG_ZERO) &&
                      (reg_hit(id_use_rs, id_rs, ex_write_addr) ||
                       reg_hit(id_use_rt, id_rt, ex_write_addr));
    assign md_stall = id_use_hilo & md_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MEMST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        freeze       = 1'b0;
        mem_req      = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;

        case (state_q)
            MEMST_IDLE: begin
                mem_req = access;
                if (access && !mem_ready) begin
                    freeze  = 1'b1;
                    state_d = MEMST_WAIT;
                end
            end
            MEMST_WAIT: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = MEMST_IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_d = MEMST_IDLE;
        endcase

        if (!reset) begin
            freeze  = 1'b0;
            mem_req = 1'b0;
        end

        // Branch/jump squashes wait out a freeze; ID/EX inputs are held and re-evaluated on release.
        if (!reset) begin
            state_d = MEMST_IDLE;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (ld_stall || md_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (id_jump) begin
            if_id_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_write_addr;
    logic       id_use_rs, id_use_rt, id_use_hilo, id_jump;
    logic       ex_MemRead, ex_branch_taken, md_start;
    logic       mem_MemRead, mem_MemWrite, mem_ready;
    logic       mem_req, pc_write, if_id_write, if_id_flush;
    logic       id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush, md_busy;

    int total = 0;
    int bad   = 0;

    // bit order: mem_req pc_write if_id_write if_id_flush id_ex_write id_ex_flush ex_mem_write mem_wb_flush md_busy
    localparam logic [8:0] NORMAL = 9'b011010100;
    localparam logic [8:0] STALL  = 9'b000011100;
    localparam logic [8:0] BRANCH = 9'b011111100;
    localparam logic [8:0] JUMP   = 9'b011110100;
    localparam logic [8:0] FREEZE = 9'b100000010;
    localparam logic [8:0] MEMGO  = 9'b111010100;
    localparam logic [8:0] MEMBR  = 9'b111111100;

    pipeline_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(6)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_use_hilo     (id_use_hilo),
        .id_jump         (id_jump),
        .ex_MemRead      (ex_MemRead),
        .ex_write_addr   (ex_write_addr),
        .ex_branch_taken (ex_branch_taken),
        .md_start        (md_start),
        .mem_MemRead     (mem_MemRead),
        .mem_MemWrite    (mem_MemWrite),
        .mem_ready       (mem_ready),
        .mem_req         (mem_req),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_flush    (mem_wb_flush),
        .md_busy         (md_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {mem_req, pc_write, if_id_write, if_id_flush, id_ex_write,
                id_ex_flush, ex_mem_write, mem_wb_flush, md_busy};
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_write_addr = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_use_hilo = 1'b0; id_jump = 1'b0;
        ex_MemRead = 1'b0; ex_branch_taken = 1'b0; md_start = 1'b0;
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        mem_MemRead = 1'b1;
        next(); #1 check("reset_forced", outs(), NORMAL);
        next(); #1 check("reset_forced2", outs(), NORMAL);

        next(); reset = 1'b1; clear_inputs(); #1 check("idle", outs(), NORMAL);

        next(); ex_MemRead = 1'b1; ex_write_addr = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        #1 check("ld_use_rs", outs(), STALL);
        next(); ex_MemRead = 1'b0; #1 check("ld_use_gone", outs(), NORMAL);

        next(); clear_inputs(); ex_MemRead = 1'b1; ex_write_addr = 5'd8;
        id_rs = 5'd3; id_use_rs = 1'b1; id_rt = 5'd8; id_use_rt = 1'b1;
        #1 check("ld_use_rt", outs(), STALL);
        next(); id_use_rt = 1'b0; #1 check("rt_not_used", outs(), NORMAL);

        next(); clear_inputs(); ex_MemRead = 1'b1; ex_write_addr = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1 check("ld_r0_nostall", outs(), NORMAL);
        next(); ex_branch_taken = 1'b1; #1 check("branch", outs(), BRANCH);

        next(); ex_write_addr = 5'd8; id_rs = 5'd8; #1 check("branch_over_stall", outs(), BRANCH);
        next(); clear_inputs(); id_jump = 1'b1; #1 check("jump", outs(), JUMP);
        next(); ex_MemRead = 1'b1; ex_write_addr = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
        #1 check("stall_over_jump", outs(), STALL);

        next(); clear_inputs(); mem_MemWrite = 1'b1; mem_ready = 1'b1;
        #1 check("mem_zero_wait", outs(), MEMGO);

        next(); clear_inputs(); mem_MemRead = 1'b1; ex_branch_taken = 1'b1; id_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("freeze_%0d", i), outs(), FREEZE);
            next();
        end
        mem_ready = 1'b1; #1 check("freeze_release_branch", outs(), MEMBR);
        next(); clear_inputs(); #1 check("back_idle", outs(), NORMAL);

        next(); md_start = 1'b1; #1 check("md_start_cycle", outs(), NORMAL);
        next(); md_start = 1'b0; id_use_hilo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("md_stall_%0d", i), outs(), STALL | 9'b1);
            next();
        end
        #1 check("md_done", outs(), NORMAL);

        next(); clear_inputs(); md_start = 1'b1; mem_MemRead = 1'b1;
        #1 check("md_start_frozen", outs(), FREEZE);
        next(); md_start = 1'b0; mem_ready = 1'b1; #1 check("md_start_ignored", outs(), MEMGO);

        next(); clear_inputs(); md_start = 1'b1; #1 check("md_start2", outs(), NORMAL);
        next(); md_start = 1'b0; mem_MemRead = 1'b1; #1 check("freeze_busy", outs(), FREEZE | 9'b1);
        next(); #1 check("wait_busy", outs(), FREEZE | 9'b1);
        next(); reset = 1'b0; #1 check("reset_in_wait", outs(), NORMAL);
        next(); reset = 1'b1; mem_MemRead = 1'b0; #1 check("after_reset_idle", outs(), NORMAL);
        next(); mem_MemRead = 1'b1; mem_ready = 1'b1; #1 check("after_reset_zero_wait", outs(), MEMGO);

        next(); clear_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
